axi_read_only_mem_ctrl: RTL

AXI_READ_ONLY_MEM_CTRL -- requirements
Module: axi_read_only_mem_ctrl

---
 rtl/axi_read_only_mem_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_read_only_mem_ctrl.sv
// AXI4 read-only slave in front of a single-port synchronous SRAM, with credit-limited 2-entry R buffer.
// Optional macro AXI_RD_RANGE_CHECK_EN: out-of-range AR addresses return SLVERR beats without touching memory.
module axi_read_only_mem_ctrl #(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_RDATA_WIDTH   = 64,
    parameter int AXI4_ID_WIDTH      = 16,
    parameter int AXI4_USER_WIDTH    = 10,
    parameter int AXI_NUMBYTES       = AXI4_RDATA_WIDTH / 8,
    parameter int MEM_ADDR_WIDTH     = 13
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic [AXI4_ID_WIDTH-1:0]      ARID_i,
    input  logic [AXI4_ADDRESS_WIDTH-1:0] ARADDR_i,
    input  logic [7:0]                    ARLEN_i,
    input  logic [2:0]                    ARSIZE_i,
    input  logic [1:0]                    ARBURST_i,
    input  logic                          ARLOCK_i,
    input  logic [3:0]                    ARCACHE_i,
    input  logic [2:0]                    ARPROT_i,
    input  logic [3:0]                    ARREGION_i,
    input  logic [AXI4_USER_WIDTH-1:0]    ARUSER_i,
    input  logic [3:0]                    ARQOS_i,
    input  logic                          ARVALID_i,
    output logic                          ARREADY_o,

    output logic [AXI4_ID_WIDTH-1:0]      RID_o,
    output logic [AXI4_RDATA_WIDTH-1:0]   RDATA_o,
    output logic [1:0]                    RRESP_o,
    output logic                          RLAST_o,
    output logic [AXI4_USER_WIDTH-1:0]    RUSER_o,
    output logic                          RVALID_o,
    input  logic                          RREADY_i,

    output logic                          MEM_CEN_o,
    output logic                          MEM_WEN_o,
    output logic [MEM_ADDR_WIDTH-1:0]     MEM_A_o,
    output logic [AXI4_RDATA_WIDTH-1:0]   MEM_D_o,
    output logic [AXI_NUMBYTES-1:0]       MEM_BE_o,
    input  logic [AXI4_RDATA_WIDTH-1:0]   MEM_Q_i,

    output logic                          valid_o,
    input  logic                          grant_i
);

    localparam int OFFSET_BIT = $clog2(AXI4_RDATA_WIDTH) - 3;
    localparam int WORD_MSB   = MEM_ADDR_WIDTH + OFFSET_BIT - 1;

    typedef enum logic [0:0] {IDLE, BURST} state_t;

    state_t                        r_state;
    logic [AXI4_ID_WIDTH-1:0]      r_id;
    logic [AXI4_USER_WIDTH-1:0]    r_user;
    logic [MEM_ADDR_WIDTH-1:0]     r_base;
    logic [7:0]                    r_len;
    logic [7:0]                    r_beat;
    logic                          r_rangeErr;

    logic                          r_infl;
    logic [AXI4_ID_WIDTH-1:0]      r_inflId;
    logic [AXI4_USER_WIDTH-1:0]    r_inflUser;
    logic                          r_inflLast;
    logic                          r_inflErr;

    logic [AXI4_RDATA_WIDTH-1:0]   r_fifoData [2];
    logic [AXI4_ID_WIDTH-1:0]      r_fifoId   [2];
    logic [AXI4_USER_WIDTH-1:0]    r_fifoUser [2];
    logic                          r_fifoLast [2];
    logic                          r_fifoErr  [2];
    logic                          r_wrPtr;
    logic                          r_rdPtr;
    logic [1:0]                    r_count;

    logic                          w_arRangeErr;
    logic [MEM_ADDR_WIDTH-1:0]     w_arWord;
    logic                          w_pop;
    logic [2:0]                    w_occ;
    logic                          w_credit;
    logic                          w_inBurst;
    logic                          w_issue;
    logic                          w_memRead;
    logic                          w_headFromStore;
    logic                          w_popStore;
    logic                          w_writeStore;
    logic [AXI4_RDATA_WIDTH-1:0]   w_incData;
    logic                          w_unused;

`ifdef AXI_RD_RANGE_CHECK_EN
    assign w_arRangeErr = |ARADDR_i[AXI4_ADDRESS_WIDTH-1:WORD_MSB+1];
`else
    assign w_arRangeErr = 1'b0;
`endif

    assign w_arWord = ARADDR_i[WORD_MSB:OFFSET_BIT];
    assign w_unused = ^{ARSIZE_i, ARBURST_i, ARLOCK_i, ARCACHE_i, ARPROT_i,
                        ARREGION_i, ARQOS_i, ARADDR_i};

    // The read in flight counts as occupancy: it lands next cycle whether or not the master pops.
    assign w_pop     = RVALID_o & RREADY_i;
    assign w_occ     = {1'b0, r_count} + {2'b00, r_infl} - {2'b00, w_pop};
    assign w_credit  = (w_occ < 3'd2);
    assign w_inBurst = (r_state == BURST);
    assign valid_o   = w_inBurst & w_credit & ~r_rangeErr;
    assign w_issue   = w_inBurst & w_credit & (r_rangeErr | grant_i);
    assign w_memRead = valid_o & grant_i;

    assign ARREADY_o = (r_state == IDLE);
    assign MEM_CEN_o = ~w_memRead;
    assign MEM_WEN_o = 1'b1;
    assign MEM_A_o   = r_base + MEM_ADDR_WIDTH'(r_beat);
    assign MEM_D_o   = '0;
    assign MEM_BE_o  = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_id       <= '0;
            r_user     <= '0;
            r_base     <= '0;
            r_len      <= '0;
            r_beat     <= '0;
            r_rangeErr <= 1'b0;
            r_infl     <= 1'b0;
            r_inflId   <= '0;
            r_inflUser <= '0;
            r_inflLast <= 1'b0;
            r_inflErr  <= 1'b0;
        end else begin
            r_infl     <= w_issue;
            r_inflId   <= r_id;
            r_inflUser <= r_user;
            r_inflLast <= (r_beat == r_len);
            r_inflErr  <= r_rangeErr;
            case (r_state)
                IDLE: begin
                    if (ARVALID_i) begin
                        r_id       <= ARID_i;
                        r_user     <= ARUSER_i;
                        r_base     <= w_arWord;
                        r_len      <= ARLEN_i;
                        r_beat     <= '0;
                        r_rangeErr <= w_arRangeErr;
                        r_state    <= BURST;
                    end
                end
                BURST: begin
                    if (w_issue) begin
                        r_beat <= r_beat + 8'd1;
                        if (r_beat == r_len) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // An empty buffer is bypassed so memory data reaches R the cycle it returns.
    assign w_headFromStore = (r_count != 2'd0);
    assign w_popStore      = w_pop & w_headFromStore;
    assign w_writeStore    = r_infl & ~(w_pop & ~w_headFromStore);
    assign w_incData       = r_inflErr ? '0 : MEM_Q_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_fifoData[i] <= '0;
                r_fifoId[i]   <= '0;
                r_fifoUser[i] <= '0;
                r_fifoLast[i] <= 1'b0;
                r_fifoErr[i]  <= 1'b0;
            end
            r_wrPtr <= 1'b0;
            r_rdPtr <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_writeStore) begin
                r_fifoData[r_wrPtr] <= w_incData;
                r_fifoId[r_wrPtr]   <= r_inflId;
                r_fifoUser[r_wrPtr] <= r_inflUser;
                r_fifoLast[r_wrPtr] <= r_inflLast;
                r_fifoErr[r_wrPtr]  <= r_inflErr;
                r_wrPtr             <= ~r_wrPtr;
            end
            if (w_popStore) begin
                r_rdPtr <= ~r_rdPtr;
            end
            case ({w_writeStore, w_popStore})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign RVALID_o = w_headFromStore | r_infl;
    assign RDATA_o  = w_headFromStore ? r_fifoData[r_rdPtr] : w_incData;
    assign RID_o    = w_headFromStore ? r_fifoId[r_rdPtr]   : r_inflId;
    assign RUSER_o  = w_headFromStore ? r_fifoUser[r_rdPtr] : r_inflUser;
    assign RLAST_o  = w_headFromStore ? r_fifoLast[r_rdPtr] : r_inflLast;
    assign RRESP_o  = (w_headFromStore ? r_fifoErr[r_rdPtr] : r_inflErr) ? 2'b10 : 2'b00;

endmodule
